// File: rtl/ramdownstream_ctrl.sv
// Read-modify-write controller and arbiter in front of the ramdownstream
// cancelled-order accumulator RAM: accumulate, query and bulk-clear sources.
module ramdownstream_ctrl #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5,
  parameter int A_MAX   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               acc_valid,
  output logic               acc_ready,
  input  logic [A_WIDTH-1:0] acc_client,
  input  logic [D_WIDTH-1:0] acc_amount,
  input  logic               qry_valid,
  output logic               qry_ready,
  input  logic [A_WIDTH-1:0] qry_client,
  output logic               rsp_valid,
  output logic [D_WIDTH-1:0] rsp_data,
  input  logic               clr_req,
  output logic               busy,
  output logic               sat_flag,
  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read,
  input  logic               ram_memwr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_RMW = 3'd1,
    ACC_ACK = 3'd2,
    QRY_RD  = 3'd3,
    CLEAR   = 3'd4
  } state_t;

  localparam logic               SRC_ACC  = 1'b0;
  localparam logic               SRC_QRY  = 1'b1;
  localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(A_MAX - 1);

  // Returns {overflow, saturated sum}; an overflowing add clamps to all-ones.
  function automatic logic [D_WIDTH:0] sat_add(input logic [D_WIDTH-1:0] a,
                                               input logic [D_WIDTH-1:0] b);
    logic [D_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[D_WIDTH]) begin
      sat_add = {1'b1, {D_WIDTH{1'b1}}};
    end else begin
      sat_add = sum;
    end
  endfunction

  state_t             state_r, state_s;
  logic               rr_last_r, rr_last_s;
  logic               clr_pend_r, clr_pend_s;
  logic               sat_flag_r, sat_flag_s;
  logic               rsp_valid_r, rsp_valid_s;
  logic [D_WIDTH-1:0] rsp_data_r, rsp_data_s;
  logic [A_WIDTH-1:0] clr_cnt_r, clr_cnt_s;
  logic [A_WIDTH-1:0] client_r, client_s;
  logic [D_WIDTH-1:0] amount_r, amount_s;

  logic               clr_go_s;
  logic               acc_pref_s, qry_pref_s;
  logic               acc_ready_s, qry_ready_s;
  logic               we_s;
  logic [A_WIDTH-1:0] addr_w_s, addr_r_s;
  logic [D_WIDTH-1:0] data_w_s;
  logic [D_WIDTH:0]   sum_s;

  // Next-state, arbitration and RAM pin decode.
  always_comb begin
    state_s     = state_r;
    rr_last_s   = rr_last_r;
    clr_pend_s  = clr_pend_r;
    sat_flag_s  = sat_flag_r;
    rsp_valid_s = 1'b0;
    rsp_data_s  = rsp_data_r;
    clr_cnt_s   = clr_cnt_r;
    client_s    = client_r;
    amount_s    = amount_r;
    acc_ready_s = 1'b0;
    qry_ready_s = 1'b0;
    we_s        = 1'b0;
    addr_w_s    = client_r;
    addr_r_s    = client_r;
    data_w_s    = {D_WIDTH{1'b0}};
    sum_s       = {(D_WIDTH+1){1'b0}};

    clr_go_s   = clr_pend_r | clr_req;
    // Readies look only at the competing valid, never at their own.
    acc_pref_s = ~qry_valid | (rr_last_r == SRC_QRY);
    qry_pref_s = ~acc_valid | (rr_last_r == SRC_ACC);

    if (clr_req && (state_r != IDLE)) begin
      clr_pend_s = 1'b1;
    end else begin
      clr_pend_s = clr_pend_s;
    end

    case (state_r)
      IDLE: begin
        if (clr_go_s) begin
          state_s   = CLEAR;
          clr_cnt_s = {A_WIDTH{1'b0}};
        end else begin
          acc_ready_s = acc_pref_s;
          qry_ready_s = qry_pref_s;
          if (acc_valid && acc_pref_s) begin
            client_s = acc_client;
            amount_s = acc_amount;
            state_s  = ACC_RMW;
            if (qry_valid) begin
              rr_last_s = SRC_ACC;
            end else begin
              rr_last_s = rr_last_r;
            end
          end else if (qry_valid && qry_pref_s) begin
            client_s = qry_client;
            state_s  = QRY_RD;
            if (acc_valid) begin
              rr_last_s = SRC_QRY;
            end else begin
              rr_last_s = rr_last_r;
            end
          end else begin
            state_s = IDLE;
          end
        end
      end
      ACC_RMW: begin
        sum_s    = sat_add(ram_data_read, amount_r);
        data_w_s = sum_s[D_WIDTH-1:0];
        we_s     = 1'b1;
        if (sum_s[D_WIDTH]) begin
          sat_flag_s = 1'b1;
        end else begin
          sat_flag_s = sat_flag_r;
        end
        state_s = ACC_ACK;
      end
      ACC_ACK: begin
        // A missing memwr is a RAM-side fault; the request is not retried.
        if (ram_memwr) begin
          state_s = IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      QRY_RD: begin
        rsp_data_s  = ram_data_read;
        rsp_valid_s = 1'b1;
        state_s     = IDLE;
      end
      CLEAR: begin
        addr_w_s = clr_cnt_r;
        data_w_s = {D_WIDTH{1'b0}};
        we_s     = 1'b1;
        if (clr_cnt_r == LAST_IDX) begin
          clr_cnt_s  = {A_WIDTH{1'b0}};
          sat_flag_s = 1'b0;
          clr_pend_s = 1'b0;
          state_s    = IDLE;
        end else begin
          clr_cnt_s = clr_cnt_r + A_WIDTH'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      rr_last_r   <= SRC_QRY;
      clr_pend_r  <= 1'b0;
      sat_flag_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {D_WIDTH{1'b0}};
      clr_cnt_r   <= {A_WIDTH{1'b0}};
      client_r    <= {A_WIDTH{1'b0}};
      amount_r    <= {D_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      rr_last_r   <= rr_last_s;
      clr_pend_r  <= clr_pend_s;
      sat_flag_r  <= sat_flag_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      clr_cnt_r   <= clr_cnt_s;
      client_r    <= client_s;
      amount_r    <= amount_s;
    end
  end

  assign acc_ready         = acc_ready_s;
  assign qry_ready         = qry_ready_s;
  assign rsp_valid         = rsp_valid_r;
  assign rsp_data          = rsp_data_r;
  assign busy              = (state_r != IDLE);
  assign sat_flag          = sat_flag_r;
  assign ram_address_write = addr_w_s;
  assign ram_data_write    = data_w_s;
  assign ram_write_enable  = we_s;
  assign ram_address_read  = addr_r_s;

endmodule

// File: tb/tb_ramdownstream_ctrl.sv
// Self-checking bench for ramdownstream_ctrl with a behavioural RAM model
// and a response scoreboard.
module tb_ramdownstream_ctrl;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int AM = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          acc_valid, acc_ready;
  logic [AW-1:0] acc_client;
  logic [DW-1:0] acc_amount;
  logic          qry_valid, qry_ready;
  logic [AW-1:0] qry_client;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          clr_req, busy, sat_flag;
  logic [AW-1:0] ram_address_write, ram_address_read;
  logic [DW-1:0] ram_data_write, ram_data_read;
  logic          ram_write_enable;
  logic          ram_memwr = 1'b0;

  logic [DW-1:0] mem [AM] = '{default: 16'h0000};

  ramdownstream_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .A_MAX(AM)) dut (
    .clk(clk), .rst_n(rst_n),
    .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_client(acc_client), .acc_amount(acc_amount),
    .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_client(qry_client),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .clr_req(clr_req), .busy(busy), .sat_flag(sat_flag),
    .ram_address_write(ram_address_write), .ram_data_write(ram_data_write),
    .ram_write_enable(ram_write_enable), .ram_address_read(ram_address_read),
    .ram_data_read(ram_data_read), .ram_memwr(ram_memwr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address_write] <= ram_data_write;
    ram_memwr <= ram_write_enable;
  end
  assign ram_data_read = mem[ram_address_read];

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int rsp_cnt = 0;
  logic [DW-1:0] sb [$];

  typedef struct {
    logic          is_qry;
    logic [AW-1:0] client;
    logic [DW-1:0] amount;
    logic [DW-1:0] exp_val;
    logic          exp_sat;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // One clock: land 1 time unit after the edge and run the per-cycle monitors.
  task automatic tick();
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    if (ram_write_enable) we_cnt++;
    if (busy) check("ready_while_busy", {30'd0, acc_ready, qry_ready}, 32'd0);
    if (rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        fail_now("rsp_unexpected");
      end else begin
        e = sb.pop_front();
        check("rsp_data", {16'd0, rsp_data}, {16'd0, e});
      end
    end
  endtask

  task automatic do_acc(input logic [AW-1:0] c, input logic [DW-1:0] a,
                        output int cycles, output int we_delta);
    int n;
    int we0;
    acc_client = c;
    acc_amount = a;
    acc_valid  = 1'b1;
    #1;
    n = 0;
    while (!acc_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    if (!acc_ready) fail_now("acc_ready_timeout");
    we0 = we_cnt;
    tick();
    acc_valid = 1'b0;
    cycles = 1;
    while (busy && cycles < 50) begin
      tick();
      cycles++;
    end
    we_delta = we_cnt - we0;
  endtask

  task automatic do_qry(input logic [AW-1:0] c, input logic [DW-1:0] expv);
    int n;
    int r0;
    qry_client = c;
    qry_valid  = 1'b1;
    #1;
    n = 0;
    while (!qry_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    if (!qry_ready) fail_now("qry_ready_timeout");
    sb.push_back(expv);
    r0 = rsp_cnt;
    tick();
    qry_valid = 1'b0;
    check("qry_rsp_early", rsp_cnt, r0);
    check("qry_busy", {31'd0, busy}, 32'd1);
    tick();
    check("qry_rsp_latency", rsp_cnt, r0 + 1);
  endtask

  initial begin
    int cyc;
    int wed;
    int n;
    int nz;
    int exp_cnt;
    logic expect_acc;

    vecs[0]  = '{1'b0, 5'd3,  16'd100,  16'd100,  1'b0};
    vecs[1]  = '{1'b0, 5'd3,  16'd250,  16'd350,  1'b0};
    vecs[2]  = '{1'b1, 5'd3,  16'd0,    16'd350,  1'b0};
    vecs[3]  = '{1'b0, 5'd7,  16'hFFF0, 16'hFFF0, 1'b0};
    vecs[4]  = '{1'b1, 5'd7,  16'd0,    16'hFFF0, 1'b0};
    vecs[5]  = '{1'b0, 5'd7,  16'h0020, 16'hFFFF, 1'b1};
    vecs[6]  = '{1'b1, 5'd7,  16'd0,    16'hFFFF, 1'b1};
    vecs[7]  = '{1'b0, 5'd7,  16'h0001, 16'hFFFF, 1'b1};
    vecs[8]  = '{1'b0, 5'd31, 16'd5,    16'd5,    1'b1};
    vecs[9]  = '{1'b1, 5'd31, 16'd0,    16'd5,    1'b1};
    vecs[10] = '{1'b0, 5'd20, 16'h1234, 16'h1234, 1'b1};
    vecs[11] = '{1'b1, 5'd3,  16'd0,    16'd350,  1'b1};

    rst_n = 1'b0;
    acc_valid = 1'b0; acc_client = 5'd0; acc_amount = 16'd0;
    qry_valid = 1'b0; qry_client = 5'd0; clr_req = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("rst_sat", {31'd0, sat_flag}, 32'd0);
    check("rst_we", {31'd0, ram_write_enable}, 32'd0);
    check("rst_addr_w", {27'd0, ram_address_write}, 32'd0);
    check("rst_addr_r", {27'd0, ram_address_read}, 32'd0);
    check("rst_data_w", {16'd0, ram_data_write}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_readies", {30'd0, acc_ready, qry_ready}, 32'd3);

    do_qry(5'd0, 16'd0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_qry) begin
        do_qry(vecs[i].client, vecs[i].exp_val);
      end else begin
        do_acc(vecs[i].client, vecs[i].amount, cyc, wed);
        check("acc_cycles", cyc, 3);
        check("acc_we_pulses", wed, 1);
        check("acc_ram_value", {16'd0, mem[vecs[i].client]}, {16'd0, vecs[i].exp_val});
      end
      check("vec_sat", {31'd0, sat_flag}, {31'd0, vecs[i].exp_sat});
    end

    // Clear requested while an accumulate sits in ACC_ACK.
    acc_client = 5'd3; acc_amount = 16'd1; acc_valid = 1'b1;
    #1;
    check("clr_acc_ready", {31'd0, acc_ready}, 32'd1);
    tick();
    acc_valid = 1'b0;
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1;
    check("clr_pend_idle_busy", {31'd0, busy}, 32'd0);
    check("clr_pend_readies", {30'd0, acc_ready, qry_ready}, 32'd0);
    check("clr_acc_done", {16'd0, mem[3]}, 32'd351);
    we_cnt = 0;
    tick();
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("clr_cycles", n, AM);
    check("clr_we_pulses", we_cnt, AM);
    nz = 0;
    for (int k = 0; k < AM; k++) if (mem[k] != 16'd0) nz++;
    check("clr_all_zero", nz, 0);
    check("clr_sat", {31'd0, sat_flag}, 32'd0);
    do_qry(5'd7, 16'd0);

    // Reset in the middle of a clear.
    do_acc(5'd0, 16'd1, cyc, wed);
    do_acc(5'd9, 16'd9, cyc, wed);
    do_acc(5'd20, 16'h0055, cyc, wed);
    check("pre_rst_e9", {16'd0, mem[9]}, 32'd9);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_we", {31'd0, ram_write_enable}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    #5;
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    nz = 0;
    for (int k = 0; k < 10; k++) if (mem[k] != 16'd0) nz++;
    check("rst_clr_low_zero", nz, 0);
    check("rst_clr_e20", {16'd0, mem[20]}, 32'h55);
    do_qry(5'd20, 16'h0055);
    do_qry(5'd9, 16'd0);

    // Both sources valid continuously: grants alternate starting with ACC.
    acc_client = 5'd5; acc_amount = 16'd1; qry_client = 5'd5;
    acc_valid = 1'b1; qry_valid = 1'b1;
    exp_cnt = 0;
    expect_acc = 1'b1;
    for (int g = 0; g < 6; g++) begin
      #1;
      n = 0;
      while (!(acc_ready || qry_ready) && n < 50) begin
        tick();
        #1;
        n++;
      end
      check("rr_onehot", {31'd0, acc_ready ^ qry_ready}, 32'd1);
      check("rr_grant", {31'd0, acc_ready}, {31'd0, expect_acc});
      if (expect_acc) exp_cnt++;
      else sb.push_back(DW'(exp_cnt));
      tick();
      expect_acc = ~expect_acc;
    end
    acc_valid = 1'b0;
    qry_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    tick();
    check("rr_ram5", {16'd0, mem[5]}, 32'd3);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ramdownstream_ctrl.md
Name: ramdownstream_ctrl

Overview:
- Read-modify-write controller and arbiter in front of ramdownstream, the per-client cancelled-order accumulator RAM.
- Shares the single RAM write port and read port between three sources:
  - accumulate requests (add a cancelled amount to a client's running total);
  - query requests (read a client's total);
  - a bulk clear sequencer (zero every client entry).
- Sits between the order-cancel decode logic and ramdownstream. Owns all RAM address, data and enable pins.

Parameters:
- D_WIDTH, 16, accumulator width in bits; must match the RAM.
- A_WIDTH, 5, client-ID width.
- A_MAX, 32, number of RAM entries (2^A_WIDTH).

Ports:
- clk  input  1  single clock; also drives the RAM clk_read/clk_write.
- rst_n  input  1  reset, asynchronous, active-low.
- acc_valid  input  1  accumulate request valid.
- acc_ready  output  1  accumulate accepted when valid && ready.
- acc_client  input  A_WIDTH  client ID to accumulate.
- acc_amount  input  D_WIDTH  amount to add.
- qry_valid  input  1  query request valid.
- qry_ready  output  1  query accepted when valid && ready.
- qry_client  input  A_WIDTH  client ID to read.
- rsp_valid  output  1  one-cycle pulse, query result valid.
- rsp_data  output  D_WIDTH  query result.
- clr_req  input  1  one-cycle pulse requesting a clear of all entries.
- busy  output  1  high whenever the FSM is not IDLE.
- sat_flag  output  1  sticky; set when any accumulate saturated.
- ram_address_write  output  A_WIDTH  to RAM downstream_address_write.
- ram_data_write  output  D_WIDTH  to RAM data_write.
- ram_write_enable  output  1  to RAM downstream_write_enable.
- ram_address_read  output  A_WIDTH  to RAM address_read.
- ram_data_read  input  D_WIDTH  from RAM data_read (combinational read).
- ram_memwr  input  1  from RAM memwr; high the cycle after a write edge.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state = IDLE; rr_last = QRY, so the first contest grants ACC.
  - clr_pend, sat_flag, rsp_valid = 0; rsp_data = 0; clear counter = 0.
  - ram_write_enable = 0; ram addresses/data = 0.
  - acc_ready/qry_ready evaluate combinationally from IDLE.
- States: IDLE, ACC_RMW, ACC_ACK, QRY_RD, CLEAR.
- IDLE priority:
  1. clr_pend or clr_req → CLEAR. Both readies are 0 this cycle.
  2. One of acc_valid/qry_valid → grant that source.
  3. Both valid → round-robin: grant the source opposite rr_last, then update rr_last.
- acc_ready = IDLE && no clear pending && ACC is the winner. qry_ready likewise. Readies may depend on the other valid; they never depend on their own valid.
- Accumulate path, 3 cycles per request, back-to-back capable:
  - Accept cycle: latch client and amount → ACC_RMW.
  - ACC_RMW:
    - ram_address_read = ram_address_write = client.
    - sum = ram_data_read + amount, computed at D_WIDTH+1 bits.
    - If sum bit D_WIDTH is set, write all-ones and set sat_flag. Otherwise write the low D_WIDTH bits.
    - ram_write_enable = 1 for exactly this cycle → ACC_ACK.
  - ACC_ACK: wait for ram_memwr = 1, then → IDLE.
    - ram_memwr = 0 in ACC_ACK is a fault. Return to IDLE anyway; no retry.
- Query path, 2 cycles:
  - Accept cycle → QRY_RD.
  - QRY_RD: ram_address_read = client. Register ram_data_read into rsp_data. rsp_valid = 1 for the next cycle only → IDLE.
  - No write in QRY_RD.
- Same-client accumulate then query: the query observes the updated value. The write lands on the ACC_RMW edge, before any QRY_RD.
- CLEAR:
  - Counter 0..A_MAX-1; one entry per cycle with ram_data_write = 0 and ram_write_enable = 1.
  - After the A_MAX-1 write: clear sat_flag and clr_pend → IDLE.
  - Total A_MAX cycles.
- clr_req outside IDLE sets clr_pend. It is served at the next IDLE ahead of any pending acc/qry. Multiple pulses collapse into one.
- ram_write_enable is high only in ACC_RMW and CLEAR. It is driven combinationally from state, so an async reset drops it immediately.
- Reset mid-operation:
  - An in-flight accumulate is dropped. The RAM holds either the old or the new value, never partial data.
  - A clear is abandoned; entries already zeroed stay zero.
- Client ID wrap: addresses are A_WIDTH bits and never exceed A_MAX-1.

Test Plan:
- Reset, then acc(client 3, 100), then acc(3, 250) → RAM[3] = 350; 3 cycles each; ram_write_enable high for 1 cycle per acc; sat_flag = 0.
- RAM[7] = 0xFFF0, acc(7, 0x0020) → RAM[7] = 0xFFFF; sat_flag = 1 and stays set.
- acc_valid and qry_valid held high continuously (acc 5/+1, qry 5) → grants alternate ACC, QRY, ACC…; each rsp_data equals the preceding accumulated value (1, 2, 3…).
- Query client 0 after reset → rsp_valid pulse 2 cycles after accept; rsp_data = 0.
- clr_req pulsed during ACC_ACK with entries 3 and 7 non-zero → acc completes; CLEAR runs 32 cycles; all entries read 0; sat_flag = 0; no ready asserted during CLEAR.
- rst_n asserted low in CLEAR at counter 10 → ram_write_enable = 0 immediately; busy = 0 after release; entries 0–9 read 0; entry 20's prior value is intact.
